color_adj_key_ctrl: RTL and testbench

Key-driven controller that sequences the brightness/colour-offset datapath in the video path. It debounces three push-buttons (mode, up, down) and steps a channel-select FSM (ALL/R/G/B). It keeps saturating 3-bit shadow gain codes and commits them to the datapath control inputs only at a frame boundary (vsync leading edge), so no frame ever shows a mid-frame change. Outputs drive rgb_ctrl_plus10, r_ctrl_plus10, g_ctrl_plus10 and b_ctrl_plus10 of the colour-adjust stage directly.

---
 rtl/color_adj_key_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_color_adj_key_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/color_adj_key_ctrl.sv
// color_adj_key_ctrl
//   Push-button controller for the colour-adjust stage. It debounces the
//   mode/up/down keys and steps a channel select (ALL/R/G/B). It edits
//   saturating 3-bit shadow gain codes, and copies the shadows to the
//   datapath control outputs only on the leading edge of vsync. This keeps
//   every frame's gain settings constant for the whole frame.
//
//   Optional build macro: AUTO_REPEAT_EN
//     When defined, a held up/down key auto-repeats. The first repeat comes
//     REPEAT_DLY cycles after the first pulse, then one every REPEAT_CYC
//     cycles. When undefined, each press produces exactly one pulse.
//
// Ports
//   clk               sole clock
//   rst               synchronous active-high reset
//   key_mode          raw mode button, asynchronous, active level KEY_ACT
//   key_up            raw increment button, asynchronous
//   key_down          raw decrement button, asynchronous
//   vs_in             vertical sync; the commit edge is the entry into VS_POL
//   rgb_ctrl_plus10   committed common gain code
//   r_ctrl_plus10     committed red gain code
//   g_ctrl_plus10     committed green gain code
//   b_ctrl_plus10     committed blue gain code
//   sel               select state (FSM state): 0=ALL 1=R 2=G 3=B
//   pending           shadows hold edits that are not yet committed
//   commit            one-cycle pulse in the cycle the outputs take new values
module color_adj_key_ctrl #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter bit KEY_ACT      = 1'b0,
    parameter bit VS_POL       = 1'b1,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_CYC   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       vs_in,
    output logic [2:0] rgb_ctrl_plus10,
    output logic [2:0] r_ctrl_plus10,
    output logic [2:0] g_ctrl_plus10,
    output logic [2:0] b_ctrl_plus10,
    output logic [1:0] sel,
    output logic       pending,
    output logic       commit
);

    localparam int              DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0] DB_ARM = DB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        SEL_ALL = 2'd0,
        SEL_R   = 2'd1,
        SEL_G   = 2'd2,
        SEL_B   = 2'd3
    } sel_e;

    // Key index: 0 = mode, 1 = up, 2 = down
    logic [2:0]      key_raw;
    logic [2:0]      sync1, sync2;
    logic [2:0]      pressed;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      key_pulse;
    logic [2:0]      edit_pulse;

    assign key_raw = {key_down, key_up, key_mode};
    assign pressed = KEY_ACT ? sync2 : ~sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= {3{~KEY_ACT}};
            sync2 <= {3{~KEY_ACT}};
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // The counter holds at DB_MAX while the key stays down. The pulse is
    // registered, so it is high in the same cycle the counter shows DB_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
            key_pulse <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!pressed[i]) begin
                    db_cnt[i]    <= '0;
                    key_pulse[i] <= 1'b0;
                end else if (db_cnt[i] != DB_MAX) begin
                    db_cnt[i]    <= db_cnt[i] + 1'b1;
                    key_pulse[i] <= (db_cnt[i] == DB_ARM);
                end else begin
                    key_pulse[i] <= 1'b0;
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int              RP_MAX   = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
    localparam int              RP_W     = $clog2(RP_MAX + 1);
    localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DLY - 1);
    localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_CYC - 1);

    // Repeat slot j serves key j+1 (up, down). The mode key never repeats.
    logic [RP_W-1:0] rep_cnt [2];
    logic [1:0]      rep_first;
    logic [1:0]      rep_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 2; j++) rep_cnt[j] <= '0;
            rep_first <= 2'b11;
            rep_pulse <= 2'b00;
        end else begin
            for (int j = 0; j < 2; j++) begin
                // Repeat timing starts in the first cycle after the debounce pulse.
                if (!pressed[j+1] || db_cnt[j+1] != DB_MAX) begin
                    rep_cnt[j]   <= '0;
                    rep_first[j] <= 1'b1;
                    rep_pulse[j] <= 1'b0;
                end else if (rep_cnt[j] == (rep_first[j] ? RP_FIRST : RP_NEXT)) begin
                    rep_cnt[j]   <= '0;
                    rep_first[j] <= 1'b0;
                    rep_pulse[j] <= 1'b1;
                end else begin
                    rep_cnt[j]   <= rep_cnt[j] + 1'b1;
                    rep_pulse[j] <= 1'b0;
                end
            end
        end
    end

    assign edit_pulse = key_pulse | {rep_pulse, 1'b0};
`else
    localparam int unused_repeat_cfg = REPEAT_DLY + REPEAT_CYC;
    assign edit_pulse = key_pulse;
`endif

    logic mode_p, up_p, down_p;
    assign mode_p = edit_pulse[0];
    assign up_p   = edit_pulse[1];
    assign down_p = edit_pulse[2];

    // Select FSM
    sel_e sel_q, sel_nxt;

    always_ff @(posedge clk) begin
        if (rst) sel_q <= SEL_ALL;
        else     sel_q <= sel_nxt;
    end

    always_comb begin
        sel_nxt = sel_q;
        if (mode_p) begin
            case (sel_q)
                SEL_ALL: sel_nxt = SEL_R;
                SEL_R:   sel_nxt = SEL_G;
                SEL_G:   sel_nxt = SEL_B;
                default: sel_nxt = SEL_ALL;
            endcase
        end
    end

    // Shadow edit. Shadow index matches the select encoding (0 = common).
    // An edit always uses the current sel, so a coincident mode pulse
    // changes sel only after the edit has been applied.
    logic [2:0] shadow     [4];
    logic [2:0] shadow_nxt [4];
    logic [2:0] out_q      [4];
    logic [1:0] sel_idx;
    logic [2:0] cur;
    logic       changed;

    assign sel_idx = sel_q;
    assign cur     = shadow[sel_idx];

    always_comb begin
        for (int k = 0; k < 4; k++) shadow_nxt[k] = shadow[k];
        changed = 1'b0;
        if (up_p && !down_p && cur != 3'd7) begin
            shadow_nxt[sel_idx] = cur + 3'd1;
            changed             = 1'b1;
        end else if (down_p && !up_p && cur != 3'd0) begin
            shadow_nxt[sel_idx] = cur - 3'd1;
            changed             = 1'b1;
        end
    end

    // Commit on the vsync leading edge. The outputs copy the pre-edit
    // shadows, so an edit in the same cycle keeps pending set for the next frame.
    logic vs_d, vs_edge, commit_now, pending_q, commit_q;

    assign vs_edge    = (vs_in == VS_POL) && (vs_d != VS_POL);
    assign commit_now = vs_edge && pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                shadow[k] <= 3'd0;
                out_q[k]  <= 3'd0;
            end
            vs_d      <= VS_POL;
            pending_q <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                shadow[k] <= shadow_nxt[k];
                if (commit_now) out_q[k] <= shadow[k];
            end
            vs_d      <= vs_in;
            pending_q <= changed | (pending_q & ~commit_now);
            commit_q  <= commit_now;
        end
    end

    assign rgb_ctrl_plus10 = out_q[0];
    assign r_ctrl_plus10   = out_q[1];
    assign g_ctrl_plus10   = out_q[2];
    assign b_ctrl_plus10   = out_q[3];
    assign sel             = sel_q;
    assign pending         = pending_q;
    assign commit          = commit_q;

endmodule

// File: tb/tb_color_adj_key_ctrl.sv
// Testbench for color_adj_key_ctrl. It runs the design with
// DEBOUNCE_CYC=4, REPEAT_DLY=20, REPEAT_CYC=8, VS_POL=1 and active-low keys.
// A table of key/vsync operations is checked, each against hand-computed
// outputs. Hand-written sequences cover press latency with bounce, an edit
// that coincides with the vsync edge, reset during operation, and key hold
// (auto-repeat).
module tb_color_adj_key_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_mode, key_up, key_down, vs_in;
    logic [2:0] rgb_ctrl_plus10, r_ctrl_plus10, g_ctrl_plus10, b_ctrl_plus10;
    logic [1:0] sel;
    logic       pending, commit;

    color_adj_key_ctrl #(
        .DEBOUNCE_CYC(4),
        .KEY_ACT     (1'b0),
        .VS_POL      (1'b1),
        .REPEAT_DLY  (20),
        .REPEAT_CYC  (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_mode       (key_mode),
        .key_up         (key_up),
        .key_down       (key_down),
        .vs_in          (vs_in),
        .rgb_ctrl_plus10(rgb_ctrl_plus10),
        .r_ctrl_plus10  (r_ctrl_plus10),
        .g_ctrl_plus10  (g_ctrl_plus10),
        .b_ctrl_plus10  (b_ctrl_plus10),
        .sel            (sel),
        .pending        (pending),
        .commit         (commit)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog timeout");
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [2:0] AR_EXP = 3'd6;
`else
    localparam logic [2:0] AR_EXP = 3'd1;
`endif

    localparam logic [2:0] K_NONE = 3'b000;
    localparam logic [2:0] K_M    = 3'b100;
    localparam logic [2:0] K_U    = 3'b010;
    localparam logic [2:0] K_D    = 3'b001;

    // is_vs: pulse vsync; otherwise press keys (mode,up,down) cnt times,
    // each press held for 'hold' raw cycles. Expected values are the
    // commit-pulse count during the op and the outputs afterwards.
    typedef struct {
        logic       is_vs;
        logic [2:0] keys;
        int         cnt;
        int         hold;
        logic [1:0] cc;
        logic [2:0] rgb, r, g, b;
        logic [1:0] sel;
        logic       pend;
    } vec_t;

    vec_t        tbl [28];
    logic [16:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          commit_cnt = 0;

    // ---------------- scoreboard ----------------
    function automatic logic [16:0] pack(logic [1:0] cc, logic [2:0] rgb, logic [2:0] r,
                                         logic [2:0] g, logic [2:0] b, logic [1:0] s, logic p);
        return {cc, rgb, r, g, b, s, p};
    endfunction

    function automatic logic [16:0] actual_vec();
        logic [1:0] cc;
        cc = (commit_cnt > 3) ? 2'd3 : commit_cnt[1:0];
        return pack(cc, rgb_ctrl_plus10, r_ctrl_plus10, g_ctrl_plus10, b_ctrl_plus10, sel, pending);
    endfunction

    task automatic check_val(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        logic [16:0] exp;
        exp = exp_q.pop_front();
        check_val(name, actual_vec(), exp);
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (commit === 1'b1) commit_cnt++;
    endtask

    task automatic set_keys(input logic [2:0] k);
        key_mode = ~k[2];
        key_up   = ~k[1];
        key_down = ~k[0];
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = tbl[i];
        commit_cnt = 0;
        exp_q.push_back(pack(v.cc, v.rgb, v.r, v.g, v.b, v.sel, v.pend));
        if (v.is_vs) begin
            vs_in = 1'b1;
            tick();
            tick();
            vs_in = 1'b0;
            repeat (3) tick();
        end else begin
            for (int n = 0; n < v.cnt; n++) begin
                set_keys(v.keys);
                repeat (v.hold) tick();
                set_keys(K_NONE);
                repeat (6) tick();
            end
        end
        sb_check($sformatf("vec%0d", i));
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) run_vec(i);
    endtask

    // ---------------- test ----------------
    initial begin
        rst   = 1'b1;
        vs_in = 1'b0;
        set_keys(K_NONE);

        //            vs    keys       cnt hold cc    rgb   r     g     b     sel   pend
        tbl[0]  = '{1'b1, K_NONE,    0,  0, 2'd1, 3'd1, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, K_NONE,    0,  0, 2'd0, 3'd1, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, K_M,       1, 10, 2'd0, 3'd1, 3'd0, 3'd0, 3'd0, 2'd1, 1'b0};
        tbl[3]  = '{1'b0, K_D,       1, 10, 2'd0, 3'd1, 3'd0, 3'd0, 3'd0, 2'd1, 1'b0};
        tbl[4]  = '{1'b0, K_M,       1, 10, 2'd0, 3'd1, 3'd0, 3'd0, 3'd0, 2'd2, 1'b0};
        tbl[5]  = '{1'b0, K_U,       9, 10, 2'd0, 3'd1, 3'd0, 3'd0, 3'd0, 2'd2, 1'b1};
        tbl[6]  = '{1'b1, K_NONE,    0,  0, 2'd1, 3'd1, 3'd0, 3'd7, 3'd0, 2'd2, 1'b0};
        tbl[7]  = '{1'b0, K_U,       1, 10, 2'd0, 3'd1, 3'd0, 3'd7, 3'd0, 2'd2, 1'b0};
        tbl[8]  = '{1'b1, K_NONE,    0,  0, 2'd0, 3'd1, 3'd0, 3'd7, 3'd0, 2'd2, 1'b0};
        tbl[9]  = '{1'b0, K_U | K_D, 1, 10, 2'd0, 3'd1, 3'd0, 3'd7, 3'd0, 2'd2, 1'b0};
        tbl[10] = '{1'b0, K_D,       1, 10, 2'd0, 3'd1, 3'd0, 3'd7, 3'd0, 2'd2, 1'b1};
        tbl[11] = '{1'b0, K_U | K_D, 1, 10, 2'd0, 3'd1, 3'd0, 3'd7, 3'd0, 2'd2, 1'b1};
        tbl[12] = '{1'b1, K_NONE,    0,  0, 2'd1, 3'd1, 3'd0, 3'd6, 3'd0, 2'd2, 1'b0};
        tbl[13] = '{1'b0, K_U,       1,  3, 2'd0, 3'd1, 3'd0, 3'd6, 3'd0, 2'd2, 1'b0};
        tbl[14] = '{1'b0, K_M | K_U, 1, 10, 2'd0, 3'd1, 3'd0, 3'd6, 3'd0, 2'd3, 1'b1};
        tbl[15] = '{1'b0, K_U,       2, 10, 2'd0, 3'd1, 3'd0, 3'd6, 3'd0, 2'd3, 1'b1};
        tbl[16] = '{1'b0, K_M,       1, 10, 2'd0, 3'd1, 3'd0, 3'd6, 3'd0, 2'd0, 1'b1};
        tbl[17] = '{1'b0, K_D,       1, 10, 2'd0, 3'd1, 3'd0, 3'd6, 3'd0, 2'd0, 1'b1};
        tbl[18] = '{1'b1, K_NONE,    0,  0, 2'd1, 3'd0, 3'd0, 3'd7, 3'd2, 2'd0, 1'b0};
        tbl[19] = '{1'b0, K_M,       1, 10, 2'd0, 3'd0, 3'd0, 3'd7, 3'd2, 2'd1, 1'b0};
        tbl[20] = '{1'b0, K_U,       1, 10, 2'd0, 3'd0, 3'd0, 3'd7, 3'd2, 2'd1, 1'b1};
        tbl[21] = '{1'b1, K_NONE,    0,  0, 2'd1, 3'd0, 3'd2, 3'd7, 3'd2, 2'd1, 1'b0};
        tbl[22] = '{1'b0, K_U,       1, 10, 2'd0, 3'd0, 3'd2, 3'd7, 3'd2, 2'd1, 1'b1};
        tbl[23] = '{1'b0, K_U,       1, 10, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1};
        tbl[24] = '{1'b1, K_NONE,    0,  0, 2'd1, 3'd1, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0};
        tbl[25] = '{1'b0, K_D,       1, 10, 2'd0, 3'd1, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1};
        tbl[26] = '{1'b1, K_NONE,    0,  0, 2'd1, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0};
        tbl[27] = '{1'b1, K_NONE,    0,  0, 2'd1, AR_EXP, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0};

        // Reset state
        commit_cnt = 0;
        repeat (3) tick();
        check_val("reset", actual_vec(), pack(2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0));
        rst = 1'b0;
        tick();

        // Bouncy up press: pulse DEBOUNCE_CYC+2 cycles after the stable
        // start, so pending shows one cycle later.
        commit_cnt = 0;
        key_up = 1'b0; tick();
        key_up = 1'b1; tick();
        key_up = 1'b0; tick();
        key_up = 1'b1; tick();
        key_up = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) check_val("pend_before_pulse", 17'(pending), 17'd0);
            if (k == 7) check_val("pend_after_pulse", 17'(pending), 17'd1);
        end
        key_up = 1'b1;
        repeat (6) tick();
        exp_q.push_back(pack(2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1));
        sb_check("up_held_until_vs");

        run_range(0, 20);

        // Up pulse lands on the vsync edge while pending: the commit takes
        // r=1 (pre-edit) and pending stays set for the new value 2.
        commit_cnt = 0;
        key_up = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7) begin
                check_val("coin_commit", 17'(commit), 17'd1);
                check_val("coin_r_value", 17'(r_ctrl_plus10), 17'd1);
                check_val("coin_pending", 17'(pending), 17'd1);
                vs_in = 1'b0;
            end
            if (k == 6) vs_in = 1'b1;
        end
        key_up = 1'b1;
        repeat (6) tick();

        run_range(21, 22);

        // Reset in the middle of operation discards the pending edit.
        commit_cnt = 0;
        rst = 1'b1;
        repeat (2) tick();
        check_val("reset_mid", actual_vec(), pack(2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0));
        rst = 1'b0;
        tick();

        run_range(23, 26);

        // Hold up: raw low for 60 cycles, so the key is held 54 cycles after
        // its first pulse (covers repeats at +20..+52, stops before +60).
        commit_cnt = 0;
        key_up = 1'b0;
        repeat (60) tick();
        key_up = 1'b1;
        repeat (6) tick();
        exp_q.push_back(pack(2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1));
        sb_check("hold_pending");

        run_range(27, 27);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
